ddr3_ref_arb: RTL

DDR3_REF_ARB -- requirements
Module: ddr3_ref_arb

---
 rtl/ddr3_ref_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ddr3_ref_arb.sv
// DDR3 refresh arbiter: muxes configurator / memory-controller commands onto the DDL port
// and inserts precharge-all + back-to-back refresh bursts for postponed tREFI ticks.
module ddr3_ref_arb #(
   parameter int DDR_ROW_BITS = 13,
   parameter int REF_MAX      = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cfg_run_i,
   input  logic                    cfg_req_i,
   input  logic [2:0]              cfg_cmd_i,
   input  logic [2:0]              cfg_ba_i,
   input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
   output logic                    cfg_rdy_o,
   input  logic                    cfg_ref_i,
   input  logic                    fsm_req_i,
   input  logic                    fsm_seq_i,
   input  logic [2:0]              fsm_cmd_i,
   input  logic [2:0]              fsm_ba_i,
   input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
   output logic                    fsm_rdy_o,
   output logic                    fsm_hold_o,
   output logic                    ddl_req_o,
   output logic                    ddl_seq_o,
   output logic [2:0]              ddl_cmd_o,
   output logic [2:0]              ddl_ba_o,
   output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
   input  logic                    ddl_rdy_i,
   output logic                    ref_ovf_o
);

   localparam int PW = $clog2(REF_MAX + 1);
   localparam logic [2:0] CMD_NOOP = 3'b111;
   localparam logic [2:0] CMD_PREC = 3'b010;
   localparam logic [2:0] CMD_REFR = 3'b001;
   localparam logic [DDR_ROW_BITS-1:0] ADR_PALL = DDR_ROW_BITS'(1) << 10;

   typedef enum logic [2:0] {INIT, MEM, DRAIN, PREA, REFR} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] pend;
   logic          in_seq;
   logic          tick, refr_xfer, fsm_xfer, want_ref;

   assign tick      = cfg_ref_i & cfg_run_i;
   assign refr_xfer = (state == REFR) & ddl_rdy_i;
   assign fsm_xfer  = fsm_req_i & fsm_rdy_o;
   // A tick this cycle already counts, so an idle controller is held off without a dead cycle.
   assign want_ref  = (pend != '0) | tick;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         pend      <= '0;
         in_seq    <= 1'b0;
         ref_ovf_o <= 1'b0;
      end else begin
         state <= state_nx;
         if (fsm_xfer)
            in_seq <= fsm_seq_i;
         // Tick together with a refresh transfer nets to zero.
         if (tick && !refr_xfer) begin
            if (pend == PW'(REF_MAX))
               ref_ovf_o <= 1'b1;
            else
               pend <= pend + 1'b1;
         end else if (!tick && refr_xfer) begin
            pend <= pend - 1'b1;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      ddl_req_o  = 1'b0;
      ddl_seq_o  = 1'b0;
      ddl_cmd_o  = CMD_NOOP;
      ddl_ba_o   = '0;
      ddl_adr_o  = '0;
      cfg_rdy_o  = 1'b0;
      fsm_rdy_o  = 1'b0;
      fsm_hold_o = 1'b0;
      case (state)
         INIT: begin
            ddl_req_o = cfg_req_i;
            ddl_cmd_o = cfg_req_i ? cfg_cmd_i : CMD_NOOP;
            ddl_ba_o  = cfg_ba_i;
            ddl_adr_o = cfg_adr_i;
            cfg_rdy_o = ddl_rdy_i;
            if (cfg_run_i && !cfg_req_i)
               state_nx = MEM;
         end
         MEM, DRAIN: begin
            ddl_req_o  = fsm_req_i;
            ddl_seq_o  = fsm_req_i & fsm_seq_i;
            ddl_cmd_o  = fsm_req_i ? fsm_cmd_i : CMD_NOOP;
            ddl_ba_o   = fsm_ba_i;
            ddl_adr_o  = fsm_adr_i;
            fsm_rdy_o  = ddl_rdy_i;
            if (state == MEM) begin
               fsm_hold_o = (pend != '0);
               // An open sequence must finish before the banks are closed.
               if (want_ref)
                  state_nx = (in_seq || (fsm_req_i && ddl_rdy_i && fsm_seq_i)) ? DRAIN : PREA;
            end else begin
               fsm_hold_o = 1'b1;
               if (!in_seq)
                  state_nx = PREA;
            end
         end
         PREA: begin
            ddl_req_o  = 1'b1;
            ddl_seq_o  = 1'b1;
            ddl_cmd_o  = CMD_PREC;
            ddl_adr_o  = ADR_PALL;
            fsm_hold_o = 1'b1;
            if (ddl_rdy_i)
               state_nx = REFR;
         end
         REFR: begin
            ddl_req_o  = 1'b1;
            ddl_seq_o  = (pend > PW'(1));
            ddl_cmd_o  = CMD_REFR;
            fsm_hold_o = 1'b1;
            if (ddl_rdy_i && pend <= PW'(1))
               state_nx = MEM;
         end
         default: state_nx = INIT;
      endcase
   end

endmodule
